// File: rtl/mem_burst_initiator.sv
// -----------------------------------------------------------------------------
// mem_burst_initiator
//
// Drives one port of a synchronous single-clock RAM. The RAM port has a
// registered read path (one cycle of read latency) and a write enable.
// The block takes burst read/write commands from a host and turns each one
// into per-beat RAM strobes. Read data goes back to the host over a
// valid/ready response channel. Two instances can serve the two ports of a
// true dual-port RAM.
//
// Ports:
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_cmd_*           command channel (valid/ready); we selects write burst,
//                     addr is the start address, len is beats minus one
//   o_cmd_ready       high only while idle, so commands are never queued
//   i_wr_*            write beat data channel (valid/ready)
//   o_rsp_*           read beat response channel (valid/ready)
//   o_mem_*           RAM address, write data and write/read strobes
//   i_mem_rdata       RAM read data, valid the cycle after o_mem_re
//   o_busy            high whenever a burst is in progress
//   o_done            one-cycle pulse in the cycle the block returns to idle
//                     after the final beat of a burst
// -----------------------------------------------------------------------------
module mem_burst_initiator #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_we,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]  i_cmd_len,

    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [DATA_W-1:0] i_wr_data,

    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,

    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    input  logic [DATA_W-1:0] i_mem_rdata,

    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_RESP  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_beat_cnt;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_done;

    logic                w_accept;
    logic                w_beat_done;
    logic                w_last_beat;

    // The beat counter holds the number of beats still to go after the
    // current one, so zero marks the final beat of the burst.
    assign w_last_beat = (r_beat_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode. Strobes are purely combinational from
    // the state (and wr_valid while writing), so leaving a state drops them
    // in the very next cycle, including after a reset.
    always_comb begin
        w_next_state = r_state;
        o_cmd_ready  = 1'b0;
        o_wr_ready   = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_re     = 1'b0;
        o_mem_wdata  = '0;
        w_accept     = 1'b0;
        w_beat_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = i_cmd_we ? S_WRITE : S_RD_ISSUE;
                end
            end
            S_WRITE: begin
                o_wr_ready  = 1'b1;
                o_mem_we    = i_wr_valid;
                o_mem_wdata = i_wr_data;
                if (i_wr_valid) begin
                    w_beat_done  = 1'b1;
                    w_next_state = w_last_beat ? S_IDLE : S_WRITE;
                end
            end
            S_RD_ISSUE: begin
                o_mem_re     = 1'b1;
                w_next_state = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_next_state = S_RD_RESP;
            end
            S_RD_RESP: begin
                if (i_rsp_ready) begin
                    w_beat_done  = 1'b1;
                    w_next_state = w_last_beat ? S_IDLE : S_RD_ISSUE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Burst bookkeeping and the response register. On the final beat the
    // address is left pointing at that beat rather than advanced, and done
    // is raised for the cycle in which the block is back in idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_beat_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_beat_done && w_last_beat;

            if (w_accept) begin
                r_addr     <= i_cmd_addr;
                r_beat_cnt <= i_cmd_len;
            end else if (w_beat_done && !w_last_beat) begin
                r_addr     <= r_addr + ADDR_W'(1);
                r_beat_cnt <= r_beat_cnt - LEN_W'(1);
            end

            // RAM data issued last cycle is valid now; capture it and hold
            // it stable until the host takes it.
            if (r_state == S_RD_WAIT) begin
                r_rsp_data  <= i_mem_rdata;
                r_rsp_valid <= 1'b1;
            end else if ((r_state == S_RD_RESP) && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_done      = r_done;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_burst_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_burst_initiator
//
// Drives mem_burst_initiator against a behavioural RAM and compares every
// cycle with a burst-level reference model. Directed scenarios pin the
// model with hand-computed values; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mem_burst_initiator;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int LEN_W  = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmdValid;
    logic              cmdReady;
    logic              cmdWe;
    logic [ADDR_W-1:0] cmdAddr;
    logic [LEN_W-1:0]  cmdLen;
    logic              wrValid;
    logic              wrReady;
    logic [DATA_W-1:0] wrData;
    logic              rspValid;
    logic              rspReady;
    logic [DATA_W-1:0] rspData;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              memWe;
    logic              memRe;
    logic [DATA_W-1:0] memRdata;
    logic              busy;
    logic              done;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    // Behavioural RAM seen by the DUT, and the model's own copy of what the
    // RAM should contain.
    logic [DATA_W-1:0] ram    [0:DEPTH-1];
    logic [DATA_W-1:0] refMem [0:DEPTH-1];

    // Burst-level model: kind 0 idle, 1 write burst, 2 read burst. A burst
    // covers mBeats addresses starting at mStart; mBeatIdx is the beat in
    // progress; mSinceIssue counts cycles since the current read beat hit
    // the RAM.
    bit                modelValid = 1'b0;
    int                mKind, mStart, mBeats, mBeatIdx, mSinceIssue;
    logic              mDone, mRspValid;
    logic [DATA_W-1:0] mRspData;

    // Event logs collected by the compare process for the directed checks.
    int   weAddrQ[$], weDataQ[$], weCycQ[$], reAddrQ[$], rspDataQ[$], rspRiseQ[$];
    int   acceptCyc;
    logic prevRspValid = 1'b0;

    logic [DATA_W-1:0] wrQ[$];

    mem_burst_initiator #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cmd_valid(cmdValid),
        .o_cmd_ready(cmdReady),
        .i_cmd_we   (cmdWe),
        .i_cmd_addr (cmdAddr),
        .i_cmd_len  (cmdLen),
        .i_wr_valid (wrValid),
        .o_wr_ready (wrReady),
        .i_wr_data  (wrData),
        .o_rsp_valid(rspValid),
        .i_rsp_ready(rspReady),
        .o_rsp_data (rspData),
        .o_mem_addr (memAddr),
        .o_mem_wdata(memWdata),
        .o_mem_we   (memWe),
        .o_mem_re   (memRe),
        .i_mem_rdata(memRdata),
        .o_busy     (busy),
        .o_done     (done)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Single-port RAM with a registered read, as the DUT expects to see.
    always @(posedge clk) begin
        if (memWe === 1'b1) ram[memAddr] = memWdata;
        if (memRe === 1'b1) memRdata <= ram[memAddr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkSeq(input string name, input int got[$], input int want[$]);
        checkOutput({name, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size(); i++) begin
            checkOutput(name, (i < got.size()) ? got[i] : -1, want[i]);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        weAddrQ.delete(); weDataQ.delete(); weCycQ.delete();
        reAddrQ.delete(); rspDataQ.delete(); rspRiseQ.delete();
    endtask

    // Offer a command and hold it until the accepting edge has passed.
    task automatic applyStimulus(input bit we, input int addr, input int len);
        cmdValid = 1'b1;
        cmdWe    = we;
        cmdAddr  = ADDR_W'(addr);
        cmdLen   = LEN_W'(len);
        for (int i = 0; i < 50; i++) begin
            if (cmdReady) break;
            stepCycle();
        end
        checkOutput("cmd_accept", cmdReady, 1);
        stepCycle();
        cmdValid = 1'b0;
    endtask

    // Push every entry of wrQ as a write beat, with up to gapMax idle
    // cycles in front of each one.
    task automatic writeBurst(input int gapMax);
        for (int i = 0; i < wrQ.size(); i++) begin
            repeat ($urandom_range(0, gapMax)) begin
                wrValid = 1'b0;
                wrData  = DATA_W'($urandom);
                stepCycle();
            end
            wrValid = 1'b1;
            wrData  = wrQ[i];
            stepCycle();
        end
        wrValid = 1'b0;
        checkOutput("write_done", done, 1);
    endtask

    // Take read responses with the given readiness probability until done.
    task automatic drainRead(input int readyPct);
        for (int i = 0; i < 600; i++) begin
            rspReady = ($urandom_range(0, 99) < readyPct);
            stepCycle();
            if (done) break;
        end
        rspReady = 1'b0;
        checkOutput("read_done", done, 1);
    endtask

    // Compare process: at each falling edge check every DUT output against
    // the model, log events, then advance the model by the rising edge that
    // follows using the inputs currently applied.
    always @(negedge clk) begin : compareProc
        int   cur;
        logic nextDone;
        cyc++;
        cur = (mStart + mBeatIdx) % DEPTH;
        if (modelValid) begin
            checkOutput("busy",      busy,     mKind != 0);
            checkOutput("cmd_ready", cmdReady, mKind == 0);
            checkOutput("done",      done,     mDone);
            checkOutput("wr_ready",  wrReady,  mKind == 1);
            checkOutput("mem_we",    memWe,    (mKind == 1) && wrValid);
            checkOutput("mem_re",    memRe,    (mKind == 2) && (mSinceIssue == 0));
            checkOutput("mem_addr",  memAddr,  cur);
            checkOutput("rsp_valid", rspValid, mRspValid);
            checkOutput("rsp_data",  rspData,  mRspData);
            if (memWe) checkOutput("mem_wdata", memWdata, wrData);
            testsRun++;
            assert (!(memWe && memRe)) else begin
                testsFailed++;
                $display("[TB] FAIL we_re_exclusive: mem_we=%0b mem_re=%0b (cycle %0d)", memWe, memRe, cyc);
            end

            if (memWe) begin
                weAddrQ.push_back(int'(memAddr));
                weDataQ.push_back(int'(memWdata));
                weCycQ.push_back(cyc);
            end
            if (memRe) reAddrQ.push_back(int'(memAddr));
            if (rspValid && rspReady) rspDataQ.push_back(int'(rspData));
            if (rspValid && !prevRspValid) rspRiseQ.push_back(cyc);
            if (cmdValid && cmdReady && !rst) acceptCyc = cyc;
            prevRspValid = rspValid;
        end

        if (rst) begin
            mKind = 0; mStart = 0; mBeats = 1; mBeatIdx = 0; mSinceIssue = 0;
            mDone = 1'b0; mRspValid = 1'b0; mRspData = '0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            nextDone = 1'b0;
            case (mKind)
                0: if (cmdValid) begin
                    mStart      = int'(cmdAddr);
                    mBeats      = int'(cmdLen) + 1;
                    mBeatIdx    = 0;
                    mSinceIssue = 0;
                    mKind       = cmdWe ? 1 : 2;
                end
                1: if (wrValid) begin
                    refMem[cur] = wrData;
                    if (mBeatIdx == mBeats - 1) begin
                        mKind    = 0;
                        nextDone = 1'b1;
                    end else begin
                        mBeatIdx++;
                    end
                end
                2: if (mSinceIssue < 2) begin
                    mSinceIssue++;
                    if (mSinceIssue == 2) begin
                        mRspValid = 1'b1;
                        mRspData  = refMem[cur];
                    end
                end else if (rspReady) begin
                    mRspValid = 1'b0;
                    if (mBeatIdx == mBeats - 1) begin
                        mKind    = 0;
                        nextDone = 1'b1;
                    end else begin
                        mBeatIdx++;
                        mSinceIssue = 0;
                    end
                end
                default: ;
            endcase
            mDone = nextDone;
        end
    end

    // Guard against a hung DUT: report and stop hard.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus: reset, directed scenarios, then randomized bursts.
    initial begin : mainProc
        int want[$];
        int addr, len;
        logic [DATA_W-1:0] v;

        rst = 1'b1; cmdValid = 1'b0; cmdWe = 1'b0; cmdAddr = '0; cmdLen = '0;
        wrValid = 1'b0; wrData = '0; rspReady = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            v = DATA_W'($urandom);
            ram[i]    = v;
            refMem[i] = v;
        end
        repeat (2) stepCycle();
        rst = 1'b0;

        checkOutput("reset_busy",      busy,     0);
        checkOutput("reset_rsp_valid", rspValid, 0);
        checkOutput("reset_rsp_data",  rspData,  0);
        checkOutput("reset_done",      done,     0);
        checkOutput("reset_mem_addr",  memAddr,  0);
        checkOutput("reset_strobes",   {memWe, memRe}, 0);

        // Write burst wrapping from the top of the address space.
        clearLogs();
        applyStimulus(1'b1, 'h3E, 3);
        wrQ = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        writeBurst(0);
        checkOutput("wr1_busy_after", busy, 0);
        want = '{'h3E, 'h3F, 'h00, 'h01};
        checkSeq("wr1_addr", weAddrQ, want);
        want = '{'hA1, 'hA2, 'hA3, 'hA4};
        checkSeq("wr1_data", weDataQ, want);
        checkOutput("wr1_consecutive", weCycQ[weCycQ.size()-1] - weCycQ[0], 3);
        stepCycle();
        checkOutput("wr1_done_one_cycle", done, 0);

        // Read the same range back with the host always ready.
        clearLogs();
        rspReady = 1'b1;
        applyStimulus(1'b0, 'h3E, 3);
        drainRead(100);
        want = '{'h3E, 'h3F, 'h00, 'h01};
        checkSeq("rd1_addr", reAddrQ, want);
        want = '{'hA1, 'hA2, 'hA3, 'hA4};
        checkSeq("rd1_data", rspDataQ, want);
        checkOutput("rd1_first_latency", rspRiseQ[0] - acceptCyc, 3);
        for (int i = 0; i + 1 < rspRiseQ.size(); i++) begin
            checkOutput("rd1_beat_spacing", rspRiseQ[i+1] - rspRiseQ[i], 3);
        end

        // Single-beat read held off by the host for five cycles.
        clearLogs();
        ram[16]    = 8'h5C;
        refMem[16] = 8'h5C;
        applyStimulus(1'b0, 'h10, 0);
        for (int i = 0; i < 10; i++) begin
            if (rspValid) break;
            stepCycle();
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rsp_valid", rspValid, 1);
            checkOutput("bp_rsp_data",  rspData,  'h5C);
            stepCycle();
        end
        rspReady = 1'b1;
        stepCycle();
        rspReady = 1'b0;
        checkOutput("bp_done",      done,     1);
        checkOutput("bp_rsp_clear", rspValid, 0);
        checkOutput("bp_single_re", reAddrQ.size(), 1);

        // Write with wr_valid 1,0,0,1 and a command offered mid-burst.
        clearLogs();
        applyStimulus(1'b1, 'h20, 1);
        cmdValid = 1'b1; cmdWe = 1'b0; cmdAddr = 'h05; cmdLen = '0;
        wrValid = 1'b1; wrData = 8'h11;
        checkOutput("stall_cmd_blocked", cmdReady, 0);
        stepCycle();
        wrValid = 1'b0;
        checkOutput("stall_cmd_blocked", cmdReady, 0);
        stepCycle();
        stepCycle();
        wrValid = 1'b1; wrData = 8'h22; cmdValid = 1'b0;
        stepCycle();
        wrValid = 1'b0;
        checkOutput("stall_done", done, 1);
        want = '{'h20, 'h21};
        checkSeq("stall_addr", weAddrQ, want);
        want = '{'h11, 'h22};
        checkSeq("stall_data", weDataQ, want);
        checkOutput("stall_spacing", weCycQ[weCycQ.size()-1] - weCycQ[0], 3);

        // Reset while a long read is in flight, after its second beat.
        clearLogs();
        rspReady = 1'b1;
        applyStimulus(1'b0, 'h08, 7);
        for (int i = 0; i < 30; i++) begin
            if (rspDataQ.size() >= 2) break;
            stepCycle();
        end
        checkOutput("rst_two_beats", rspDataQ.size(), 2);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        rspReady = 1'b0;
        checkOutput("rst_busy",      busy,     0);
        checkOutput("rst_rsp_valid", rspValid, 0);
        checkOutput("rst_mem_re",    memRe,    0);
        checkOutput("rst_done",      done,     0);
        checkOutput("rst_cmd_ready", cmdReady, 1);
        want = '{'h08, 'h09, 'h0A};
        checkSeq("rst_re_addr", reAddrQ, want);
        stepCycle();
        checkOutput("rst_no_done", done, 0);
        wrQ = '{8'h77};
        applyStimulus(1'b1, 'h3E, 0);
        writeBurst(0);

        // Back-to-back: a read of the same range waits during a write.
        clearLogs();
        applyStimulus(1'b1, 'h30, 2);
        cmdValid = 1'b1; cmdWe = 1'b0; cmdAddr = 'h30; cmdLen = 2;
        wrQ = '{DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom)};
        writeBurst(1);
        checkOutput("b2b_ready_in_done", cmdReady, 1);
        stepCycle();
        cmdValid = 1'b0;
        checkOutput("b2b_accepted", busy, 1);
        drainRead(100);
        want.delete();
        foreach (wrQ[i]) want.push_back(int'(wrQ[i]));
        checkSeq("b2b_data", rspDataQ, want);

        // Randomized bursts with write gaps and response backpressure.
        for (int n = 0; n < 40; n++) begin
            addr = $urandom_range(0, DEPTH - 1);
            len  = ($urandom_range(0, 3) == 0) ? (1 << LEN_W) - 1 : $urandom_range(0, (1 << LEN_W) - 1);
            if ($urandom_range(0, 1) == 1) begin
                wrQ.delete();
                for (int i = 0; i <= len; i++) wrQ.push_back(DATA_W'($urandom));
                applyStimulus(1'b1, addr, len);
                writeBurst(2);
            end else begin
                applyStimulus(1'b0, addr, len);
                drainRead(70);
            end
            repeat ($urandom_range(0, 2)) stepCycle();
        end

        repeat (3) stepCycle();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
